// File: rtl/fc_decision_pkg.sv
// Shared types and constants for the FC decision block: binary16 field layout,
// alarm FSM state encoding and small helpers.
package fc_decision_pkg;

   localparam int unsigned SIGN_W   = 1;
   localparam int unsigned EXP_W    = 5;
   localparam int unsigned MANT_W   = 10;
   localparam int unsigned FP16_W   = SIGN_W + EXP_W + MANT_W;
   localparam int unsigned MAG_W    = EXP_W + MANT_W;
   localparam int unsigned STREAK_W = 4;
   localparam int unsigned CNT_W    = 16;

   localparam logic [EXP_W-1:0] NAN_EXP = 5'h1F;

   typedef struct packed {
      logic [SIGN_W-1:0] sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fp16_t;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_ARMING,
      ST_ALARM,
      ST_RELEASING
   } alarm_state_t;

   function automatic logic fp16_is_nan(input fp16_t v);
      return (v.exp == NAN_EXP) && (v.mant != '0);
   endfunction

endpackage

// File: rtl/fc_decision_cmp.sv
// Combinational binary16 a >= b under sign-magnitude total order; NaN ranks
// below everything, two NaNs tie, +0 equals -0.
module fp16_cmp_ge
   import fc_decision_pkg::*;
(
   input  logic [FP16_W-1:0] a,
   input  logic [FP16_W-1:0] b,
   output logic              a_ge_b
);

   fp16_t             fa;
   fp16_t             fb;
   logic              nan_a;
   logic              nan_b;
   logic [MAG_W-1:0]  mag_a;
   logic [MAG_W-1:0]  mag_b;

   assign fa    = fp16_t'(a);
   assign fb    = fp16_t'(b);
   assign nan_a = fp16_is_nan(fa);
   assign nan_b = fp16_is_nan(fb);
   assign mag_a = {fa.exp, fa.mant};
   assign mag_b = {fb.exp, fb.mant};

   always_comb begin
      a_ge_b = 1'b1;
      if (nan_a && nan_b) begin
         a_ge_b = 1'b1;
      end else if (nan_a) begin
         a_ge_b = 1'b0;
      end else if (nan_b) begin
         a_ge_b = 1'b1;
      end else if ((mag_a == '0) && (mag_b == '0)) begin
         a_ge_b = 1'b1;
      end else if (fa.sign != fb.sign) begin
         a_ge_b = (fa.sign == 1'b0);
      end else if (fa.sign == 1'b0) begin
         a_ge_b = (mag_a >= mag_b);
      end else begin
         // both negative: smaller magnitude is the larger value
         a_ge_b = (mag_a <= mag_b);
      end
   end

endmodule

// File: rtl/fc_decision.sv
// Two-stage FC logit classifier (human vs background) with debounced alarm
// FSM and saturating frame statistics.
module fc_decision
   import fc_decision_pkg::*;
#(
   parameter int unsigned datawidth      = 16,
   parameter int unsigned output_nodes   = 2,
   parameter int unsigned CONFIRM_FRAMES = 3,
   parameter int unsigned RELEASE_FRAMES = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              fc_done,
   input  logic [datawidth*output_nodes-1:0] fc_data,
   input  logic                              clear,
   output logic                              class_valid,
   output logic                              class_id,
   output logic                              human_alarm,
   output logic [CNT_W-1:0]                  human_frames,
   output logic [CNT_W-1:0]                  total_frames
);

   localparam int unsigned DATA_W = datawidth * output_nodes;
   localparam logic [STREAK_W-1:0] CONFIRM_N = STREAK_W'(CONFIRM_FRAMES);
   localparam logic [STREAK_W-1:0] RELEASE_N = STREAK_W'(RELEASE_FRAMES);
   localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

   logic                s1_valid;
   logic [DATA_W-1:0]   s1_data;
   logic                is_human_c;
   alarm_state_t        state;
   logic [STREAK_W-1:0] streak;
   logic [STREAK_W-1:0] streak_inc_c;

   assign streak_inc_c = streak + STREAK_W'(1);

   fp16_cmp_ge u_cmp (
      .a      (s1_data[2*datawidth-1:datawidth]),
      .b      (s1_data[datawidth-1:0]),
      .a_ge_b (is_human_c)
   );

   // stage 1: capture logits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= fc_done;
         if (fc_done) begin
            s1_data <= fc_data;
         end
      end
   end

   // stage 2: registered class result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         class_valid <= 1'b0;
         class_id    <= 1'b0;
      end else begin
         class_valid <= s1_valid;
         if (s1_valid) begin
            class_id <= is_human_c;
         end
      end
   end

   // Alarm FSM advances on the same edge that raises class_valid so the
   // alarm level lines up with the class pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_CLEAR;
         streak      <= '0;
         human_alarm <= 1'b0;
      end else if (clear) begin
         state       <= ST_CLEAR;
         streak      <= '0;
         human_alarm <= 1'b0;
      end else if (s1_valid) begin
         case (state)
            ST_CLEAR: begin
               if (is_human_c) begin
                  streak <= STREAK_W'(1);
                  if (CONFIRM_N == STREAK_W'(1)) begin
                     state       <= ST_ALARM;
                     human_alarm <= 1'b1;
                  end else begin
                     state <= ST_ARMING;
                  end
               end
            end
            ST_ARMING: begin
               if (is_human_c) begin
                  streak <= streak_inc_c;
                  if (streak_inc_c == CONFIRM_N) begin
                     state       <= ST_ALARM;
                     human_alarm <= 1'b1;
                  end
               end else begin
                  state  <= ST_CLEAR;
                  streak <= '0;
               end
            end
            ST_ALARM: begin
               if (!is_human_c) begin
                  streak <= STREAK_W'(1);
                  if (RELEASE_N == STREAK_W'(1)) begin
                     state       <= ST_CLEAR;
                     human_alarm <= 1'b0;
                  end else begin
                     state <= ST_RELEASING;
                  end
               end
            end
            ST_RELEASING: begin
               if (!is_human_c) begin
                  streak <= streak_inc_c;
                  if (streak_inc_c == RELEASE_N) begin
                     state       <= ST_CLEAR;
                     human_alarm <= 1'b0;
                  end
               end else begin
                  state  <= ST_ALARM;
                  streak <= '0;
               end
            end
            default: begin
               state       <= ST_CLEAR;
               streak      <= '0;
               human_alarm <= 1'b0;
            end
         endcase
      end
   end

   // saturating frame statistics
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_frames <= '0;
         human_frames <= '0;
      end else if (clear) begin
         total_frames <= '0;
         human_frames <= '0;
      end else if (s1_valid) begin
         if (total_frames != CNT_MAX) begin
            total_frames <= total_frames + CNT_W'(1);
         end
         if (is_human_c && (human_frames != CNT_MAX)) begin
            human_frames <= human_frames + CNT_W'(1);
         end
      end
   end

endmodule
